// File: rtl/music_pkg.sv
// music_pkg: shared widths, sample rate, FSM states and note-to-step helper for the music datapath
package music_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam int STEP_W = 20;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_RATE = 48000;
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  function automatic logic [STEP_W-1:0] note_step(int n);
    real hz;
    hz = 55.0 * (2.0 ** (real'(n - 1) / 12.0));
    return (n == 0) ? '0 : STEP_W'($rtoi(hz * 4194304.0 / real'(SAMPLE_RATE)));
  endfunction
endpackage

// File: rtl/note_to_step.sv
// note_to_step: combinational ROM mapping a note number to its {10.10} phase step
module note_to_step #(
  parameter int NOTE_W = music_pkg::NOTE_W
) (
  input  logic [NOTE_W-1:0]             note,
  output logic [music_pkg::STEP_W-1:0]  step
);
  import music_pkg::*;
  logic [STEP_W-1:0] rom [2**NOTE_W];
  for (genvar i = 0; i < 2**NOTE_W; i++) begin : g_rom
    localparam logic [STEP_W-1:0] V = note_step(i);
    assign rom[i] = V;
  end
  assign step = rom[note];
endmodule

// File: rtl/note_player.sv
// note_player: plays one note by stepping sine_reader on codec requests and counting beats to its end
module note_player #(
  parameter int NOTE_W = music_pkg::NOTE_W,
  parameter int DUR_W  = music_pkg::DUR_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play_enable,
  input  logic [NOTE_W-1:0]               note,
  input  logic [DUR_W-1:0]                duration,
  input  logic                            load_new_note,
  input  logic                            beat,
  input  logic                            generate_next_sample,
  output logic [music_pkg::STEP_W-1:0]    sine_step_size,
  output logic                            sine_generate_next,
  input  logic [music_pkg::SAMPLE_W-1:0]  sine_sample,
  input  logic                            sine_sample_ready,
  output logic [music_pkg::SAMPLE_W-1:0]  sample_out,
  output logic                            new_sample_ready,
  output logic                            done_with_note
);
  import music_pkg::*;
  state_t state_q, state_d;
  logic [DUR_W-1:0] count_q, count_d;
  logic [STEP_W-1:0] step_q, step_d, rom_step;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic rest_q, rest_d, gen_q, gen_d, nsr_q, nsr_d, done_q, done_d, run;
  note_to_step #(.NOTE_W(NOTE_W)) u_rom (.note(note), .step(rom_step));
  assign run = (state_q == PLAY) && play_enable;
  // next state: load wins over everything, else finish on count exhausted or final beat
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    step_d = step_q;
    rest_d = rest_q;
    done_d = 1'b0;
    gen_d = run && generate_next_sample;
    nsr_d = run && sine_sample_ready;
    sample_d = nsr_d ? (rest_q ? '0 : sine_sample) : sample_q;
    if (load_new_note) begin
      state_d = PLAY;
      count_d = duration;
      step_d = rom_step;
      rest_d = (note == '0);
    end else if (state_q == DONE) begin
      state_d = IDLE;
      step_d = '0;
    end else if (state_q == PLAY && (count_q == '0 || (run && beat && count_q == DUR_W'(1)))) begin
      state_d = DONE;
      count_d = '0;
      done_d = 1'b1;
    end else if (run && beat) begin
      count_d = count_q - DUR_W'(1);
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      step_q <= '0;
      rest_q <= 1'b0;
      gen_q <= 1'b0;
      nsr_q <= 1'b0;
      sample_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      step_q <= step_d;
      rest_q <= rest_d;
      gen_q <= gen_d;
      nsr_q <= nsr_d;
      sample_q <= sample_d;
      done_q <= done_d;
    end
  end
  assign sine_step_size = step_q;
  assign sine_generate_next = gen_q;
  assign sample_out = sample_q;
  assign new_sample_ready = nsr_q;
  assign done_with_note = done_q;
endmodule
